avl_bus_ram_slave: RTL and testbench

//  Avalon-MM pipelined slave responder: the slave-side end of i_avl_bus, answering the commands that masters issue through
//  avl_bus_n2n. It is a synthesizable on-chip word RAM with fixed read latency, in-order read returns and byte-enable writes.
//  It applies waitrequest backpressure when its outstanding-read limit is reached, and can inject periodic stalls.
//  It sits on one avl_out port of avl_bus_n2n, as the RTL counterpart of the simulation-only slave models.

---
 rtl/avl_bus_ram_slave.sv | 140 ++++++++++++++
 tb/tb_avl_bus_ram_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_bus_ram_slave.sv
// avl_bus_ram_slave: Avalon-MM pipelined slave backed by an on-chip 32-bit word RAM.
// Reads return in order after a fixed latency through a {valid,data} shift pipe,
// writes honour byte enables with zero latency. waitrequest throttles new commands
// when the outstanding-read limit is reached and can optionally be forced high
// one cycle in every STALL_PERIOD to exercise master backpressure handling.
module avl_bus_ram_slave #(
    parameter int ADDR_WIDTH      = 10,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STALL_PERIOD    = 0
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] avl_address,
    input  logic        avl_read,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    input  logic [3:0]  avl_byteenable,
    output logic        avl_waitrequest,
    output logic [31:0] avl_readdata,
    output logic        avl_readdatavalid,
    output logic        proto_err
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int STALL_W = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;

    logic [31:0]             ram_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   word_idx;

    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [31:0]             pipe_dat_q [READ_LATENCY];
    logic [31:0]             pipe_dat_d [READ_LATENCY];
    logic                    proto_err_q, proto_err_d;

    logic                    stall_now;
    logic                    ret_now;
    logic                    full_now;
    logic                    rd_accept;
    logic                    wr_accept;
    logic                    misuse;

    // Only the word-select bits are decoded here; the interconnect owns the rest.
    logic                    unused_addr;
    assign unused_addr = ^{avl_address[31:ADDR_WIDTH+2], avl_address[1:0]};

    assign word_idx = avl_address[ADDR_WIDTH+1:2];

    // A return this cycle frees its slot immediately, so a full pipe does not
    // cost a bubble when it retires and accepts in the same cycle.
    assign ret_now  = pipe_vld_q[READ_LATENCY-1];
    assign full_now = (out_cnt_q == CNT_W'(MAX_OUTSTANDING)) && !ret_now;

    assign avl_waitrequest = !rest | stall_now | full_now;

    assign wr_accept = avl_write & !avl_waitrequest;
    assign rd_accept = avl_read & !avl_write & !avl_waitrequest;
    assign misuse    = avl_read & avl_write & !avl_waitrequest;

    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

            // Next stall count: free-running, wraps after STALL_PERIOD-1
            always_comb begin
                stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1)) ? '0
                                                                          : stall_cnt_q + STALL_W'(1);
            end

            // Stall counter register, restarts from zero on reset
            always_ff @(posedge clk) begin
                if (!rest) begin
                    stall_cnt_q <= '0;
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                end
            end

            assign stall_now = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));
        end else begin : g_no_stall
            assign stall_now = 1'b0;
        end
    endgenerate

    // Next-state for the read pipe, outstanding counter and sticky protocol flag
    always_comb begin
        pipe_vld_d[0] = rd_accept;
        pipe_dat_d[0] = rd_accept ? ram_q[word_idx] : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end

        out_cnt_d = out_cnt_q;
        case ({rd_accept, ret_now})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase

        proto_err_d = proto_err_q | misuse;
    end

    // Control and pipe registers; in-flight reads are discarded on reset
    always_ff @(posedge clk) begin
        if (!rest) begin
            out_cnt_q   <= '0;
            pipe_vld_q  <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat_q[i] <= 32'h0;
            end
        end else begin
            out_cnt_q   <= out_cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    // RAM write port with per-byte enables; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (avl_byteenable[b]) begin
                    ram_q[word_idx][8*b +: 8] <= avl_writedata[8*b +: 8];
                end
            end
        end
    end

    assign avl_readdata      = pipe_dat_q[READ_LATENCY-1];
    assign avl_readdatavalid = pipe_vld_q[READ_LATENCY-1];
    assign proto_err         = proto_err_q;

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// tb_avl_bus_ram_slave: scoreboard bench for avl_bus_ram_slave. The driver pushes
// the expected read data and return cycle when a read is accepted; a monitor on
// the falling edge checks waitrequest, proto_err and every readdatavalid pulse
// against a word-array reference model.
module tb_avl_bus_ram_slave;

    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int MAXO  = 2;
    localparam int STALL = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic        proto_err;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic        model_proto = 1'b0;
    int          cyc = 0;
    int          rst_edges = 0;
    int          tests = 0;
    int          failures = 0;

    avl_bus_ram_slave #(
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (LAT),
        .MAX_OUTSTANDING(MAXO),
        .STALL_PERIOD   (STALL)
    ) dut (
        .clk              (clk),
        .rest             (rest),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .proto_err        (proto_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle index since reset release, matching the free-running stall phase
    always @(posedge clk) begin
        if (!rest) begin
            cyc = 0;
            rst_edges = rst_edges + 1;
        end else begin
            cyc = cyc + 1;
            rst_edges = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests = tests + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: compares DUT outputs with the model once per cycle, mid-cycle
    always @(negedge clk) begin : monitor
        logic due_now;
        logic exp_wr;
        due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        if (!rest) begin
            checkOutput("waitrequest_in_reset", {31'b0, avl_waitrequest}, 32'd1);
            if (rst_edges >= 1) begin
                checkOutput("readdatavalid_in_reset", {31'b0, avl_readdatavalid}, 32'd0);
                checkOutput("proto_err_in_reset", {31'b0, proto_err}, 32'd0);
            end
            exp_q.delete();
            model_proto = 1'b0;
        end else begin
            exp_wr = ((cyc % STALL) == STALL - 1) || ((exp_q.size() == MAXO) && !due_now);
            checkOutput("waitrequest", {31'b0, avl_waitrequest}, {31'b0, exp_wr});
            checkOutput("proto_err", {31'b0, proto_err}, {31'b0, model_proto});
            if (due_now || avl_readdatavalid) begin
                checkOutput("readdatavalid", {31'b0, avl_readdatavalid}, {31'b0, due_now});
                if (due_now) begin
                    if (avl_readdatavalid) begin
                        checkOutput("readdata", avl_readdata, exp_q[0].data);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one command, hold it until accepted, then update the reference model
    task automatic applyStimulus(input logic rd, input logic wr, input int idx,
                                 input logic [31:0] data, input logic [3:0] be);
        logic [31:0]   addr;
        logic [AW-1:0] widx;
        int            waited;
        widx              = AW'(idx % DEPTH);
        addr              = $urandom;
        addr[AW+1:2]      = widx;
        avl_address       = addr;
        avl_read          = rd;
        avl_write         = wr;
        avl_writedata     = data;
        avl_byteenable    = be;
        waited = 0;
        while (1) begin
            @(negedge clk);
            #1;
            if (!avl_waitrequest) break;
            waited = waited + 1;
            if (waited >= 40) break;
        end
        tests = tests + 1;
        if (avl_waitrequest) begin
            failures = failures + 1;
            $display("[TB] FAIL accept_timeout: command at word 0x%03h not accepted in %0d cycles, required within 40",
                     widx, waited);
        end else begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[widx][8*b +: 8] = data[8*b +: 8];
                end
            end
            if (rd && wr) begin
                model_proto = 1'b1;
            end else if (rd) begin
                exp_q.push_back('{data: model_mem[widx], due: cyc + LAT});
            end
        end
        @(posedge clk);
        #1;
        avl_read  = 1'b0;
        avl_write = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for every expected return to be seen, bounded
    task automatic waitDrain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            @(posedge clk);
            k = k + 1;
        end
        #1;
        tests = tests + 1;
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("[TB] FAIL drain: %0d reads still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rest           = 1'b0;
        avl_address    = 32'h0;
        avl_read       = 1'b1;
        avl_write      = 1'b0;
        avl_writedata  = 32'h0;
        avl_byteenable = 4'h0;

        // Reset held with a pending read request
        repeat (5) @(posedge clk);
        #1;
        avl_read = 1'b0;
        rest     = 1'b1;

        // Preload a 64-word region that straddles the top of the address space
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 1000 + i, $urandom, 4'hF);
        end

        // Write then read the same word back to back
        applyStimulus(1'b0, 1'b1, 'h40, 32'hDEADBEEF, 4'hF);
        applyStimulus(1'b1, 1'b0, 'h40, 32'h0, 4'h0);
        waitDrain();

        // Partial byte-enable write
        applyStimulus(1'b0, 1'b1, 'h40, 32'h11223344, 4'hF);
        applyStimulus(1'b0, 1'b1, 'h40, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1'b1, 1'b0, 'h40, 32'h0, 4'h0);
        waitDrain();

        // Continuous reads against the outstanding limit
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1010 + 3 * i, 32'h0, 4'h0);
        end
        waitDrain();

        // Continuous writes through the stall pattern, then read them back
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 2 + i, $urandom, 4'hF);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 2 + i, 32'h0, 4'h0);
        end
        waitDrain();

        // Randomised traffic over the initialised region
        for (int n = 0; n < 300; n++) begin
            int r;
            int idx;
            r   = $urandom_range(0, 99);
            idx = (1000 + $urandom_range(0, 63)) % DEPTH;
            if (r < 45) begin
                applyStimulus(1'b1, 1'b0, idx, 32'h0, 4'h0);
            end else if (r < 90) begin
                applyStimulus(1'b0, 1'b1, idx, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                idleCycles($urandom_range(1, 3));
            end
        end
        waitDrain();

        // Read and write together: write lands, read dropped, sticky error
        applyStimulus(1'b1, 1'b1, 5, 32'hCAFEF00D, 4'hF);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 5, 32'h0, 4'h0);
        waitDrain();

        // Reset with two reads in flight: no returns afterwards, RAM preserved
        applyStimulus(1'b1, 1'b0, 6, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 7, 32'h0, 4'h0);
        rest = 1'b0;
        idleCycles(3);
        rest = 1'b1;
        idleCycles(8);
        applyStimulus(1'b1, 1'b0, 6, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 7, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 5, 32'h0, 4'h0);
        waitDrain();
        idleCycles(4);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #1000000;
        failures = failures + 1;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 1 ms");
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
